// File: rtl/aes_spi_pkg.sv
// Shared types and constants for the AES SPI initiator.
//   state_e     : initiator FSM states
//   TX_BITS     : bits shifted out per request (plaintext then key)
//   RX_BITS     : bits shifted in per request (ciphertext)
//   BLOCK_BITS  : AES block / key width
//   drives_load : states in which the peripheral load strobe is high
package aes_spi_pkg;

    localparam int TX_BITS    = 256;
    localparam int RX_BITS    = 128;
    localparam int BLOCK_BITS = 128;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_SETUP,
        SHIFT_OUT,
        UNLOAD,
        WAIT_DONE,
        SHIFT_IN,
        FINISH
    } state_e;

    function automatic logic drives_load(input state_e s);
        return (s == LOAD_SETUP) || (s == SHIFT_OUT) || (s == UNLOAD);
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator, mode 0 (sck idles low).
// While en is high, sck toggles every CLK_DIV clk cycles, starting with a
// full low half-period. rise_stb / fall_stb are high in the clk cycle whose
// closing edge drives sck 0->1 / 1->0, so the FSM can act on that same edge.
// Ports:
//   clk, reset (async, active low)
//   en        : run the divider; low forces sck low and rearms the count
//   sck       : SPI clock
//   rise_stb  : next edge raises sck
//   fall_stb  : next edge lowers sck
module spi_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic sck,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             sck_q, sck_d;

    always_comb begin
        cnt_d    = cnt_q;
        sck_d    = sck_q;
        rise_stb = 1'b0;
        fall_stb = 1'b0;
        if (!en) begin
            cnt_d = HALF_LAST;
            sck_d = 1'b0;
        end else if (cnt_q == '0) begin
            cnt_d    = HALF_LAST;
            sck_d    = ~sck_q;
            rise_stb = ~sck_q;
            fall_stb = sck_q;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            sck_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sck_q <= sck_d;
        end
    end

    assign sck = sck_q;

endmodule

// File: rtl/aes_spi_initiator.sv
// SPI mode-0 initiator for the AES SPI peripheral.
// Sends {plaintext, key} MSB first with load high, drops load, waits for the
// peripheral's done, then reads back the 128-bit ciphertext.
// Optional: define AES_SPI_TIMEOUT_EN to add a WAIT_DONE watchdog that pulses
// err after TIMEOUT_CYCLES; without it err is tied low.
// Ports:
//   clk, reset (async, active low)
//   start, key, plaintext : request; inputs captured when start is accepted
//   sck, mosi, miso, load : SPI link to the peripheral
//   done_in               : peripheral done (asynchronous, synchronized here)
//   cyphertext, valid     : result and its one-cycle update pulse
//   busy, err             : request in flight / watchdog expiry pulse
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for start
// LOAD_SETUP | load high, first bit on mosi, CLK_DIV cycles before sck
// SHIFT_OUT  | 256 sck periods, mosi updated on each sck fall
// UNLOAD     | load held CLK_DIV cycles after the last fall
// WAIT_DONE  | sck idle, waiting for synchronized done
// SHIFT_IN   | 128 sck periods, miso sampled as sck rises
// FINISH     | publish result, pulse valid
module aes_spi_initiator #(
    parameter int CLK_DIV        = 4,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [127:0] plaintext,
    output logic         sck,
    output logic         mosi,
    input  logic         miso,
    output logic         load,
    input  logic         done_in,
    output logic [127:0] cyphertext,
    output logic         busy,
    output logic         valid,
    output logic         err
);

    import aes_spi_pkg::*;

    generate
        if (CLK_DIV < 2) begin : g_bad_clk_div
            $error("aes_spi_initiator: CLK_DIV must be at least 2");
        end
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
            $error("aes_spi_initiator: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] HOLD_LAST = DIV_W'(CLK_DIV - 1);

    state_e                  state_q, state_d;
    logic [TX_BITS-1:0]      tx_sr_q, tx_sr_d;
    logic [RX_BITS-1:0]      rx_sr_q, rx_sr_d;
    logic [BLOCK_BITS-1:0]   ct_q, ct_d;
    logic [8:0]              bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic [1:0]              sync_q;
    logic                    mosi_q, mosi_d;
    logic                    load_q, load_d;
    logic                    busy_q, busy_d;
    logic                    valid_q, valid_d;
    logic                    sck_en, rise_stb, fall_stb;
    logic                    done_sync;

`ifdef AES_SPI_TIMEOUT_EN
    logic [31:0]             wd_cnt_q, wd_cnt_d;
    logic                    err_q, err_d;
`endif

    assign done_sync = sync_q[1];
    assign sck_en    = (state_q == SHIFT_OUT) || (state_q == SHIFT_IN);

    spi_sck_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sck_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (sck_en),
        .sck      (sck),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        ct_d       = ct_q;
        bit_cnt_d  = bit_cnt_q;
        hold_cnt_d = HOLD_LAST;
        busy_d     = busy_q;
        valid_d    = 1'b0;
`ifdef AES_SPI_TIMEOUT_EN
        wd_cnt_d   = '0;
        err_d      = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    tx_sr_d = {plaintext, key};
                    busy_d  = 1'b1;
                    state_d = LOAD_SETUP;
                end
            end
            LOAD_SETUP, UNLOAD: begin
                if (hold_cnt_q == '0) begin
                    state_d = (state_q == LOAD_SETUP) ? SHIFT_OUT : WAIT_DONE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 1'b1;
                end
            end
            SHIFT_OUT: begin
                if (fall_stb) begin
                    tx_sr_d   = {tx_sr_q[TX_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 9'(TX_BITS - 1)) begin
                        state_d = UNLOAD;
                    end
                end
            end
            WAIT_DONE: begin
                if (done_sync) begin
                    state_d = SHIFT_IN;
                end
`ifdef AES_SPI_TIMEOUT_EN
                else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                    if (wd_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
`endif
            end
            SHIFT_IN: begin
                if (rise_stb) begin
                    rx_sr_d = {rx_sr_q[RX_BITS-2:0], miso};
                end
                if (fall_stb) begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 9'(RX_BITS - 1)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                ct_d    = rx_sr_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            bit_cnt_d = '0;
        end

        // mosi follows the shift register MSB only while load is up, so the
        // line is already parked low when the peripheral sees load fall.
        load_d = drives_load(state_d);
        mosi_d = load_d ? tx_sr_d[TX_BITS-1] : 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            ct_q       <= '0;
            bit_cnt_q  <= '0;
            hold_cnt_q <= '0;
            sync_q     <= '0;
            mosi_q     <= 1'b0;
            load_q     <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            ct_q       <= ct_d;
            bit_cnt_q  <= bit_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            sync_q     <= {sync_q[0], done_in};
            mosi_q     <= mosi_d;
            load_q     <= load_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
        end
    end

`ifdef AES_SPI_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign mosi       = mosi_q;
    assign load       = load_q;
    assign busy       = busy_q;
    assign valid      = valid_q;
    assign cyphertext = ct_q;

endmodule
